// File: rtl/binmorph_pkg.sv
// Shared types and constants for the 3x3 binary morphology stage.
//   morph_op_t    : OP_ERODE (AND of the window) / OP_DILATE (OR of the window)
//   morph_state_t : FILL / RUN / DRAIN frame-sequencing states
//   PIX_FG/PIX_BG : output pixel encodings
//   morph_reduce  : applies the operation to a 3x3 window with out-of-image taps neutralised
package binmorph_pkg;

  typedef enum logic {
    OP_ERODE  = 1'b0,
    OP_DILATE = 1'b1
  } morph_op_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } morph_state_t;

  localparam logic [7:0] PIX_FG = 8'd255;
  localparam logic [7:0] PIX_BG = 8'd0;

  // win/oob are indexed row*3+col, row 0 = line above the centre, col 0 = left column.
  // Taps outside the image take the neutral value of the operation (1 for AND, 0 for OR),
  // so image borders neither shrink under erosion nor grow under dilation.
  function automatic logic morph_reduce(input logic [8:0] win,
                                        input logic [8:0] oob,
                                        input morph_op_t  op);
    logic res;
    if (op == OP_ERODE) res = &(win | oob);
    else                res = |(win & ~oob);
    return res;
  endfunction

endpackage

// File: rtl/binary_morph3x3_if.sv
// Pixel stream bundle around the morphology stage.
//   op_i            : operation select, sampled by the stage on the first pixel of a frame
//   s_valid/s_ready/s_pixel : input pixel stream (raster order)
//   m_valid/m_ready/m_pixel/m_last : output pixel stream, m_last marks the final pixel
// Handshake: a beat transfers on a rising clk edge where valid && ready are both high.
// A source holds valid and its payload stable until that beat; ready may change freely
// and a sink never waits on valid before raising ready.
// Modports: slave = the morphology stage, master = the surrounding environment.
interface binary_morph3x3_if;
  logic       op_i;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_pixel;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_pixel;
  logic       m_last;

  modport slave (
    input  op_i, s_valid, s_pixel, m_ready,
    output s_ready, m_valid, m_pixel, m_last
  );

  modport master (
    output op_i, s_valid, s_pixel, m_ready,
    input  s_ready, m_valid, m_pixel, m_last
  );
endinterface

// File: rtl/binmorph_linebuf.sv
// Two chained WIDTH-bit shift lines delaying the binary pixel stream by one and two rows.
//   clk      : clock
//   shift_en : advance both lines by one pixel
//   din      : incoming binary pixel
//   tap_w    : pixel accepted WIDTH shifts ago (same column, one row up)
//   tap_2w   : pixel accepted 2*WIDTH shifts ago (same column, two rows up)
// Contents are not reset; the consumer masks every tap that could hold stale data.
module binmorph_linebuf #(
  parameter int WIDTH = 64
) (
  input  logic clk,
  input  logic shift_en,
  input  logic din,
  output logic tap_w,
  output logic tap_2w
);

  logic [WIDTH-1:0] line0_q;
  logic [WIDTH-1:0] line1_q;

  always_ff @(posedge clk) begin
    if (shift_en) begin
      line0_q <= {line0_q[WIDTH-2:0], din};
      line1_q <= {line1_q[WIDTH-2:0], line0_q[WIDTH-1]};
    end
  end

  assign tap_w  = line0_q[WIDTH-1];
  assign tap_2w = line1_q[WIDTH-1];

endmodule

// File: rtl/binary_morph3x3.sv
// Streaming 3x3 binary erosion/dilation over a WIDTH x HEIGHT raster frame.
// Input pixels are binarised on bit 7; output pixels are PIX_FG/PIX_BG.
//   clk, rst   : clock; synchronous active-high reset
//   bus        : binary_morph3x3_if.slave (op_i, s_* input stream, m_* output stream)
//   dbg_state  : current frame-sequencing state
//   fg_count   : foreground outputs in the last completed frame
//                (present only when BINMORPH_FG_COUNT_EN is defined)
// Output k is produced when input k+WIDTH+1 is accepted, so FILL swallows WIDTH+1
// pixels silently and DRAIN flushes the final WIDTH+1 outputs with padded inputs.
module binary_morph3x3
  import binmorph_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64
) (
  input  logic                clk,
  input  logic                rst,
  binary_morph3x3_if.slave    bus,
  output morph_state_t        dbg_state
`ifdef BINMORPH_FG_COUNT_EN
  ,
  output logic [$clog2(WIDTH*HEIGHT+1)-1:0] fg_count
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  morph_state_t    state_q, state_d;
  morph_op_t       op_q;
  logic            armed_q;
  logic [RW-1:0]   in_row_q, out_row_q;
  logic [CW-1:0]   in_col_q, out_col_q;
  logic [2:0]      win_a_q, win_b_q;  // older / newer stored window columns, bit = row
  logic            m_valid_q, m_last_q;
  logic [7:0]      m_pixel_q;

  logic            s_ready_c;
  logic            slot_free;
  logic            accept;
  logic            gen;
  logic            shift_en;
  logic            din;
  logic            tap_w, tap_2w;
  logic            in_fill_end, in_frame_end, out_is_last;
  logic            top_edge, bot_edge, left_edge, right_edge;
  logic [2:0]      new_col;
  logic [8:0]      win_next, oob;
  logic            result;

  assign slot_free    = !m_valid_q || bus.m_ready;
  assign in_fill_end  = (in_row_q == RW'(1)) && (in_col_q == '0);
  assign in_frame_end = (in_row_q == ROW_LAST) && (in_col_q == COL_LAST);
  assign out_is_last  = (out_row_q == ROW_LAST) && (out_col_q == COL_LAST);
  assign accept       = bus.s_valid && s_ready_c;
  assign shift_en     = accept || gen;

  // Next-state and per-cycle control. In RUN a new output is generated exactly when an
  // input is accepted; in DRAIN a zero is shifted in for each output slot that frees up,
  // stopping once the last pixel sits in the output register.
  always_comb begin
    state_d   = state_q;
    s_ready_c = 1'b0;
    gen       = 1'b0;
    din       = bus.s_pixel[7];
    case (state_q)
      FILL: begin
        s_ready_c = armed_q;
        if (bus.s_valid && s_ready_c && in_fill_end) state_d = RUN;
      end
      RUN: begin
        s_ready_c = armed_q && slot_free;
        gen       = bus.s_valid && s_ready_c;
        if (gen && in_frame_end) state_d = DRAIN;
      end
      DRAIN: begin
        din = 1'b0;
        gen = slot_free && !(m_valid_q && m_last_q);
        if (m_valid_q && m_last_q && bus.m_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  binmorph_linebuf #(.WIDTH(WIDTH)) u_linebuf (
    .clk      (clk),
    .shift_en (shift_en),
    .din      (din),
    .tap_w    (tap_w),
    .tap_2w   (tap_2w)
  );

  // The output is computed from the window as it will look after this shift, so the
  // result lands in the output register on the same edge that accepts the input.
  assign new_col    = {din, tap_w, tap_2w};
  assign top_edge   = (out_row_q == '0);
  assign bot_edge   = (out_row_q == ROW_LAST);
  assign left_edge  = (out_col_q == '0);
  assign right_edge = (out_col_q == COL_LAST);

  always_comb begin
    win_next = '0;
    oob      = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        case (c)
          0:       win_next[r*3+c] = win_a_q[r];
          1:       win_next[r*3+c] = win_b_q[r];
          default: win_next[r*3+c] = new_col[r];
        endcase
        oob[r*3+c] = (r == 0 && top_edge) || (r == 2 && bot_edge) ||
                     (c == 0 && left_edge) || (c == 2 && right_edge);
      end
    end
  end

  assign result = morph_reduce(win_next, oob, op_q);

  // Window columns carry no reset: border masking covers any stale content.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      win_a_q <= win_b_q;
      win_b_q <= new_col;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      armed_q   <= 1'b0;
      op_q      <= OP_ERODE;
      in_row_q  <= '0;
      in_col_q  <= '0;
      out_row_q <= '0;
      out_col_q <= '0;
      m_valid_q <= 1'b0;
      m_pixel_q <= PIX_BG;
      m_last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;

      if (accept) begin
        if (state_q == FILL && in_row_q == '0 && in_col_q == '0) begin
          op_q <= morph_op_t'(bus.op_i);
        end
        if (in_col_q == COL_LAST) begin
          in_col_q <= '0;
          in_row_q <= (in_row_q == ROW_LAST) ? '0 : in_row_q + RW'(1);
        end else begin
          in_col_q <= in_col_q + CW'(1);
        end
      end

      if (gen) begin
        m_valid_q <= 1'b1;
        m_pixel_q <= result ? PIX_FG : PIX_BG;
        m_last_q  <= out_is_last;
        if (out_col_q == COL_LAST) begin
          out_col_q <= '0;
          out_row_q <= (out_row_q == ROW_LAST) ? '0 : out_row_q + RW'(1);
        end else begin
          out_col_q <= out_col_q + CW'(1);
        end
      end else if (bus.m_ready) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end
    end
  end

  assign bus.s_ready = s_ready_c;
  assign bus.m_valid = m_valid_q;
  assign bus.m_pixel = m_pixel_q;
  assign bus.m_last  = m_last_q;
  assign dbg_state   = state_q;

`ifdef BINMORPH_FG_COUNT_EN
  localparam int FGW = $clog2(WIDTH*HEIGHT+1);

  logic [FGW-1:0] fg_acc_q, fg_count_q;
  logic [FGW-1:0] fg_inc;

  assign fg_inc = {{(FGW-1){1'b0}}, m_pixel_q[7]};

  // Counts foreground beats as they leave; the total is published when the m_last beat
  // transfers and then held until the next frame completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      fg_acc_q   <= '0;
      fg_count_q <= '0;
    end else if (m_valid_q && bus.m_ready) begin
      if (m_last_q) begin
        fg_count_q <= fg_acc_q + fg_inc;
        fg_acc_q   <= '0;
      end else begin
        fg_acc_q <= fg_acc_q + fg_inc;
      end
    end
  end

  assign fg_count = fg_count_q;
`else
  // Foreground counter not built.
`endif

endmodule

// File: tb/tb_binary_morph3x3.sv
module tb_binary_morph3x3;
  import binmorph_pkg::*;

  localparam int W    = 64;
  localparam int H    = 64;
  localparam int NPIX = W * H;
  localparam int FGW  = $clog2(W*H+1);

  localparam int PAT_ALL    = 0;
  localparam int PAT_DOT    = 1;
  localparam int PAT_CORNER = 2;
  localparam int PAT_NOISE  = 3;

  typedef struct {
    int pat;
    bit op;
    bit stall;
    bit gaps;
    int exp_fg;   // required foreground output count, -1 when the image is random
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  morph_state_t dbg_state;
`ifdef BINMORPH_FG_COUNT_EN
  logic [FGW-1:0] fg_count;
`endif

  initial forever #5 clk = ~clk;

  binary_morph3x3_if bus();

  binary_morph3x3 #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
`ifdef BINMORPH_FG_COUNT_EN
    ,
    .fg_count  (fg_count)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [8:0] exp_q[$];   // {last, pixel}
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  img [H][W];
  int  model_fg;
  int  obs_fg;
  int  out_idx;
  bit  stall_mode = 1'b0;
  bit  abort = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Reference: every output is the AND (erode) or OR (dilate) of the in-image 3x3
  // neighbourhood of the binary input image; out-of-image neighbours are ignored.
  task automatic model_frame(input bit op);
    bit   acc;
    int   rr, cc;
    logic last_b;
    model_fg = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        acc = !op;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (rr >= 0 && rr < H && cc >= 0 && cc < W) begin
              if (op) acc = acc | img[rr][cc];
              else    acc = acc & img[rr][cc];
            end
          end
        end
        last_b = (r == H-1) && (c == W-1);
        exp_q.push_back({last_b, acc ? 8'd255 : 8'd0});
        model_fg += int'(acc);
      end
    end
  endtask

  task automatic make_image(input int pat);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (pat)
          PAT_ALL:    img[r][c] = 1'b1;
          PAT_DOT:    img[r][c] = (r == 10) && (c == 10);
          PAT_CORNER: img[r][c] = (r == 0) && (c == 0);
          default:    img[r][c] = ($urandom_range(0, 99) < 30);
        endcase
      end
    end
  endtask

  function automatic logic [7:0] pix_of(input bit b);
    return b ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
  endfunction

  // ---------------- driver tasks ----------------
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.m_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the beat transferred.
  task automatic drive_pixel(input logic [7:0] pix);
    int guard;
    guard = 0;
    bus.s_valid = 1'b1;
    bus.s_pixel = pix;
    @(negedge clk);
    while (!bus.s_ready && !abort) begin
      guard++;
      if (guard > 20000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL s_ready_timeout: got s_ready=0 for %0d cycles required 1", guard);
        abort = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic drive_frame(input bit op, input bit gaps, input int stop_at);
    for (int i = 0; i < NPIX; i++) begin
      if (abort || i == stop_at) return;
      if (gaps && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      // op_i only matters on the first pixel; scramble it afterwards
      bus.op_i = (i == 0) ? op : 1'($urandom_range(0, 1));
      drive_pixel(pix_of(img[i / W][i % W]));
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 30000) begin
      @(posedge clk);
      guard++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d outputs missing required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [8:0] e;
    logic [8:0] held_d;
    bit         held_v;
    held_v = 1'b0;
    held_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          n_cmp++;
          if (!bus.m_valid || {bus.m_last, bus.m_pixel} !== held_d) begin
            n_bad++;
            $display("FAIL hold_stable: got valid=%0b last=%0b pix=%0d required valid=1 last=%0b pix=%0d",
                     bus.m_valid, bus.m_last, bus.m_pixel, held_d[8], held_d[7:0]);
          end
        end
        held_v = bus.m_valid && !bus.m_ready;
        held_d = {bus.m_last, bus.m_pixel};
        if (bus.m_valid && bus.m_ready) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL extra_output: got pix=%0d last=%0b required no output", bus.m_pixel, bus.m_last);
          end else begin
            e = exp_q.pop_front();
            if ({bus.m_last, bus.m_pixel} !== e) begin
              n_bad++;
              $display("FAIL out_pixel[%0d]: got last=%0b pix=%0d required last=%0b pix=%0d",
                       out_idx, bus.m_last, bus.m_pixel, e[8], e[7:0]);
            end
          end
          if (bus.m_pixel == 8'd255) obs_fg++;
          out_idx++;
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_s_ready"}, bus.s_ready, 0);
    check({tag, "_m_valid"}, bus.m_valid, 0);
    check({tag, "_m_last"},  bus.m_last, 0);
    check({tag, "_m_pixel"}, bus.m_pixel, 0);
    check({tag, "_state"},   dbg_state, FILL);
`ifdef BINMORPH_FG_COUNT_EN
    check({tag, "_fg_count"}, fg_count, 0);
`endif
  endtask

  // rst is released at posedge+1; s_ready must stay low until the following edge.
  task automatic release_reset(input string tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check({tag, "_s_ready_first_cycle"}, bus.s_ready, 0);
    @(negedge clk);
    check({tag, "_s_ready_armed"}, bus.s_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    make_image(v.pat);
    model_frame(v.op);
    obs_fg = 0;
    out_idx = 0;
    stall_mode = v.stall;
    drive_frame(v.op, v.gaps, -1);
    wait_drain();
    stall_mode = 1'b0;
    if (v.exp_fg >= 0) check($sformatf("vec%0d_fg_outputs", idx), obs_fg, v.exp_fg);
`ifdef BINMORPH_FG_COUNT_EN
    check($sformatf("vec%0d_fg_count", idx), fg_count, model_fg);
`endif
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t vecs[7];
    int   fg_a;

    vecs[0] = '{PAT_ALL,    1'b0, 1'b0, 1'b0, 4096};
    vecs[1] = '{PAT_DOT,    1'b1, 1'b0, 1'b0, 9};
    vecs[2] = '{PAT_DOT,    1'b0, 1'b0, 1'b0, 0};
    vecs[3] = '{PAT_CORNER, 1'b1, 1'b0, 1'b0, 4};
    vecs[4] = '{PAT_DOT,    1'b1, 1'b1, 1'b1, 9};
    vecs[5] = '{PAT_NOISE,  1'b0, 1'b1, 1'b1, -1};
    vecs[6] = '{PAT_NOISE,  1'b1, 1'b0, 1'b0, -1};

    bus.op_i    = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_pixel = 8'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("por");
    release_reset("por");

    for (int i = 0; i < 7; i++) begin
      if (!abort) run_vec(vecs[i], i);
    end

    // Reset in the middle of a frame, then a clean dilated dot frame.
    if (!abort) begin
      make_image(PAT_DOT);
      model_frame(1'b1);
      out_idx = 0;
      drive_frame(1'b1, 1'b0, 1000);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_values("midrst");
      exp_q.delete();
      release_reset("midrst");
      model_frame(1'b1);
      obs_fg = 0;
      out_idx = 0;
      drive_frame(1'b1, 1'b0, -1);
      wait_drain();
      check("midrst_fg_outputs", obs_fg, 9);
`ifdef BINMORPH_FG_COUNT_EN
      check("midrst_fg_count", fg_count, 9);
`endif
    end

    // Two back-to-back frames with the operation toggled; the second is offered while
    // the first is still draining.
    if (!abort) begin
      make_image(PAT_NOISE);
      model_frame(1'b0);
      fg_a = model_fg;
      model_frame(1'b1);
      obs_fg = 0;
      out_idx = 0;
      stall_mode = 1'b1;
      drive_frame(1'b0, 1'b0, -1);
      drive_frame(1'b1, 1'b0, -1);
      wait_drain();
      stall_mode = 1'b0;
      check("b2b_fg_outputs", obs_fg, fg_a + model_fg);
`ifdef BINMORPH_FG_COUNT_EN
      check("b2b_fg_count", fg_count, model_fg);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got no completion after 150000 cycles required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
